// File: rtl/vend_change.sv
// Coin-operated vending controller: accumulates 5/10/25-cent credit, vends one item
// at PRICE, then pays back the remainder one coin per cycle.
module vend_change #(
   parameter int unsigned PRICE      = 25,
   parameter int unsigned MAX_CREDIT = 45,
   parameter int unsigned W          = 7
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         i_5c,
   input  logic         i_10c,
   input  logic         i_25c,
   input  logic         i_cancel,
   output logic         o_soda,
   output logic         o_10c,
   output logic         o_5c,
   output logic         o_reject,
   output logic         o_busy,
   output logic [W-1:0] o_credit
);

   localparam logic [W-1:0] PRICE_W = W'(PRICE);
   localparam logic [W-1:0] MAX_W   = W'(MAX_CREDIT);
   localparam logic [W-1:0] C0      = W'(0);
   localparam logic [W-1:0] C5      = W'(5);
   localparam logic [W-1:0] C10     = W'(10);
   localparam logic [W-1:0] C25     = W'(25);

   typedef enum logic [1:0] {
      COLLECT = 2'd0,
      VEND    = 2'd1,
      CHANGE  = 2'd2
   } state_t;

   state_t         state, state_next;
   logic [W-1:0]   credit, credit_next;
   logic [W-1:0]   coin, sum;
   logic           any_coin;
   logic           reject_next, soda_next, c10_next, c5_next, busy_next;

   assign any_coin = i_5c | i_10c | i_25c;
   assign o_credit = credit;

   // State, credit and all strobes are flops; strobes are preloaded from the next state.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state    <= COLLECT;
         credit   <= C0;
         o_soda   <= 1'b0;
         o_10c    <= 1'b0;
         o_5c     <= 1'b0;
         o_reject <= 1'b0;
         o_busy   <= 1'b0;
      end else begin
         state    <= state_next;
         credit   <= credit_next;
         o_soda   <= soda_next;
         o_10c    <= c10_next;
         o_5c     <= c5_next;
         o_reject <= reject_next;
         o_busy   <= busy_next;
      end
   end

   // Next-state and credit update.
   always_comb begin
      state_next  = state;
      credit_next = credit;
      reject_next = 1'b0;
      coin        = C0;
      sum         = C0;
      unique case (state)
         COLLECT: begin
            if (i_cancel) begin
               reject_next = any_coin;
               if (credit != C0) state_next = CHANGE;
            end else if (any_coin) begin
               // Only the highest-priority coin counts; the others drop silently.
               coin = i_5c ? C5 : (i_10c ? C10 : C25);
               sum  = credit + coin;
               if (sum <= MAX_W) begin
                  credit_next = sum;
                  if (sum >= PRICE_W) state_next = VEND;
               end else begin
                  reject_next = 1'b1;
               end
            end
         end
         VEND: begin
            reject_next = any_coin;
            credit_next = credit - PRICE_W;
            state_next  = (credit_next != C0) ? CHANGE : COLLECT;
         end
         CHANGE: begin
            reject_next = any_coin;
            if (credit >= C10)     credit_next = credit - C10;
            else if (credit >= C5) credit_next = credit - C5;
            else                   credit_next = C0;
            state_next = (credit_next == C0) ? COLLECT : CHANGE;
         end
         default: begin
            state_next  = COLLECT;
            credit_next = C0;
         end
      endcase
   end

   // Moore strobes as seen in the cycle following this edge.
   always_comb begin
      soda_next = (state_next == VEND);
      busy_next = (state_next != COLLECT);
      c10_next  = (state_next == CHANGE) && (credit_next >= C10);
      c5_next   = (state_next == CHANGE) && (credit_next <  C10);
   end

endmodule

// File: tb/tb_vend_change.sv
// Bench for vend_change: directed scenarios plus randomized traffic against a
// payout-queue reference model (default instance), and a PRICE=30/MAX=35 instance.
module tb_vend_change;

   localparam int unsigned W = 7;

   logic clk = 1'b0;
   logic reset = 1'b0;
   logic a5 = 0, a10 = 0, a25 = 0, acan = 0;
   logic b5 = 0, b10 = 0, b25 = 0, bcan = 0;
   logic soda1, t10_1, t5_1, rej1, busy1;
   logic soda2, t10_2, t5_2, rej2, busy2;
   logic [W-1:0] cr1, cr2;
   logic [11:0] obs1, obs2;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   vend_change dut1 (
      .clk(clk), .reset(reset), .i_5c(a5), .i_10c(a10), .i_25c(a25), .i_cancel(acan),
      .o_soda(soda1), .o_10c(t10_1), .o_5c(t5_1), .o_reject(rej1), .o_busy(busy1), .o_credit(cr1)
   );

   vend_change #(.PRICE(30), .MAX_CREDIT(35), .W(W)) dut2 (
      .clk(clk), .reset(reset), .i_5c(b5), .i_10c(b10), .i_25c(b25), .i_cancel(bcan),
      .o_soda(soda2), .o_10c(t10_2), .o_5c(t5_2), .o_reject(rej2), .o_busy(busy2), .o_credit(cr2)
   );

   assign obs1 = {soda1, t10_1, t5_1, rej1, busy1, cr1};
   assign obs2 = {soda2, t10_2, t5_2, rej2, busy2, cr2};

   // Reference model for dut1: credit while collecting, plus a queue of busy cycles,
   // each holding the strobe shown that cycle (1 soda, 2 ten, 3 five) and its credit.
   typedef struct { int code; int cr; } ev_t;
   ev_t q[$];
   int  m_credit;
   bit  m_reject;
   localparam int M_PRICE = 25;
   localparam int M_MAX   = 45;

   function automatic logic [11:0] mk(bit s, bit t, bit f, bit r, bit b, int c);
      return {s, t, f, r, b, 7'(c)};
   endfunction

   task automatic push_change(input int amount);
      int r = amount;
      while (r > 0) begin
         if (r >= 10) begin q.push_back('{2, r}); r -= 10; end
         else         begin q.push_back('{3, r}); r -= 5;  end
      end
   endtask

   task automatic model_reset();
      q.delete();
      m_credit = 0;
      m_reject = 0;
   endtask

   task automatic model_step(input bit c5, input bit c10, input bit c25, input bit can);
      bit any = c5 | c10 | c25;
      int coin;
      ev_t e;
      m_reject = 0;
      if (q.size() > 0) begin
         e = q.pop_front();
         m_reject = any;
      end else if (can) begin
         m_reject = any;
         if (m_credit > 0) begin push_change(m_credit); m_credit = 0; end
      end else if (any) begin
         coin = c5 ? 5 : (c10 ? 10 : 25);
         if (m_credit + coin <= M_MAX) begin
            m_credit += coin;
            if (m_credit >= M_PRICE) begin
               q.push_back('{1, m_credit});
               push_change(m_credit - M_PRICE);
               m_credit = 0;
            end
         end else begin
            m_reject = 1;
         end
      end
   endtask

   function automatic logic [11:0] model_out();
      if (q.size() == 0) return mk(0, 0, 0, m_reject, 0, m_credit);
      return mk(q[0].code == 1, q[0].code == 2, q[0].code == 3, m_reject, 1, q[0].cr);
   endfunction

   // One clock: inputs change at the falling edge, outputs are sampled 1 after the rise.
   task automatic step(input logic [3:0] a, input logic [3:0] b);
      @(negedge clk);
      {a5, a10, a25, acan} = a;
      {b5, b10, b25, bcan} = b;
      model_step(a[3], a[2], a[1], a[0]);
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      #3;
      checks++;
      if (obs1 !== 12'h0 || obs2 !== 12'h0) begin
         errors++;
         $display("FAIL reset_state got %h/%h want 000/000", obs1, obs2);
      end
      model_reset();
      @(negedge clk);
      reset = 1'b1;
      step(4'b0000, 4'b0000);
      checks++;
      if (obs1 !== 12'h0) begin errors++; $display("FAIL reset_idle got %h want 000", obs1); end
   endtask

   task automatic test_three_tens();
      logic [3:0] stim [5] = '{4'b0100, 4'b0100, 4'b0100, 4'b0000, 4'b0000};
      logic [11:0] want [5];
      want = '{mk(0,0,0,0,0,10), mk(0,0,0,0,0,20), mk(1,0,0,0,1,30), mk(0,0,1,0,1,5), mk(0,0,0,0,0,0)};
      for (int i = 0; i < 5; i++) begin
         step(stim[i], 4'b0000);
         checks++;
         if (obs1 !== want[i]) begin errors++; $display("FAIL three_tens[%0d] got %h want %h", i, obs1, want[i]); end
      end
   endtask

   task automatic test_max_credit();
      logic [3:0] stim [6] = '{4'b0100, 4'b0100, 4'b0010, 4'b0000, 4'b0000, 4'b0000};
      logic [11:0] want [6];
      want = '{mk(0,0,0,0,0,10), mk(0,0,0,0,0,20), mk(1,0,0,0,1,45), mk(0,1,0,0,1,20),
               mk(0,1,0,0,1,10), mk(0,0,0,0,0,0)};
      for (int i = 0; i < 6; i++) begin
         step(stim[i], 4'b0000);
         checks++;
         if (obs1 !== want[i]) begin errors++; $display("FAIL max_credit[%0d] got %h want %h", i, obs1, want[i]); end
      end
   endtask

   task automatic test_priority();
      logic [3:0] stim [4] = '{4'b0100, 4'b0100, 4'b1110, 4'b0000};
      logic [11:0] want [4];
      want = '{mk(0,0,0,0,0,10), mk(0,0,0,0,0,20), mk(1,0,0,0,1,25), mk(0,0,0,0,0,0)};
      for (int i = 0; i < 4; i++) begin
         step(stim[i], 4'b0000);
         checks++;
         if (obs1 !== want[i]) begin errors++; $display("FAIL priority[%0d] got %h want %h", i, obs1, want[i]); end
      end
   endtask

   task automatic test_cancel();
      logic [3:0] stim [5] = '{4'b0100, 4'b1000, 4'b0011, 4'b0000, 4'b0000};
      logic [11:0] want [5];
      want = '{mk(0,0,0,0,0,10), mk(0,0,0,0,0,15), mk(0,1,0,1,1,15), mk(0,0,1,0,1,5), mk(0,0,0,0,0,0)};
      for (int i = 0; i < 5; i++) begin
         step(stim[i], 4'b0000);
         checks++;
         if (obs1 !== want[i]) begin errors++; $display("FAIL cancel[%0d] got %h want %h", i, obs1, want[i]); end
      end
   endtask

   task automatic test_back_to_back();
      logic [3:0] stim [7] = '{4'b0100, 4'b0100, 4'b0010, 4'b0100, 4'b0011, 4'b1000, 4'b0000};
      logic [11:0] want [7];
      want = '{mk(0,0,0,0,0,10), mk(0,0,0,0,0,20), mk(1,0,0,0,1,45), mk(0,1,0,1,1,20),
               mk(0,1,0,1,1,10), mk(0,0,0,1,0,0), mk(0,0,0,0,0,0)};
      for (int i = 0; i < 7; i++) begin
         step(stim[i], 4'b0000);
         checks++;
         if (obs1 !== want[i]) begin errors++; $display("FAIL busy_reject[%0d] got %h want %h", i, obs1, want[i]); end
      end
   endtask

   task automatic test_ceiling_reject();
      logic [3:0] stim [5] = '{4'b0010, 4'b0010, 4'b0100, 4'b0000, 4'b0000};
      logic [11:0] want [5];
      want = '{mk(0,0,0,0,0,25), mk(0,0,0,1,0,25), mk(1,0,0,0,1,35), mk(0,0,1,0,1,5), mk(0,0,0,0,0,0)};
      for (int i = 0; i < 5; i++) begin
         step(4'b0000, stim[i]);
         checks++;
         if (obs2 !== want[i]) begin errors++; $display("FAIL ceiling[%0d] got %h want %h", i, obs2, want[i]); end
      end
   endtask

   task automatic test_reset_mid_payout();
      step(4'b0100, 4'b0000);
      step(4'b0100, 4'b0000);
      step(4'b0010, 4'b0000);
      step(4'b0000, 4'b0000);
      checks++;
      if (obs1 !== mk(0,1,0,0,1,20)) begin errors++; $display("FAIL payout_start got %h want %h", obs1, mk(0,1,0,0,1,20)); end
      #2 reset = 1'b0;
      #1;
      checks++;
      if (obs1 !== 12'h0) begin errors++; $display("FAIL async_reset got %h want 000", obs1); end
      model_reset();
      @(negedge clk);
      reset = 1'b1;
      for (int i = 0; i < 4; i++) begin
         step(4'b0000, 4'b0000);
         checks++;
         if (obs1 !== 12'h0) begin errors++; $display("FAIL after_reset[%0d] got %h want 000", i, obs1); end
      end
   endtask

   task automatic test_random();
      logic [3:0] a;
      for (int i = 0; i < 400; i++) begin
         a[3] = ($urandom_range(3) == 0);
         a[2] = ($urandom_range(3) == 0);
         a[1] = ($urandom_range(3) == 0);
         a[0] = ($urandom_range(15) == 0);
         step(a, 4'b0000);
         checks++;
         if (obs1 !== model_out()) begin
            errors++;
            $display("FAIL random[%0d] in %b got %h want %h", i, a, obs1, model_out());
         end
      end
   endtask

   initial begin
      test_reset();
      test_three_tens();
      test_max_credit();
      test_priority();
      test_cancel();
      test_back_to_back();
      test_ceiling_reject();
      test_reset_mid_payout();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/vend_change.md
VEND_CHANGE -- requirements
Module: vend_change

Interface
REQ-001 Parameter PRICE, default 25, item price in cents; SHALL be a nonzero multiple of 5.
REQ-002 Parameter MAX_CREDIT, default 45, credit ceiling in cents; SHALL be a multiple of 5 and >= PRICE.
REQ-003 Parameter W, default 7, credit register width; SHALL satisfy 2**W > MAX_CREDIT+25.
REQ-004 clk  input  1  single clock; all state changes on the rising edge.
REQ-005 reset  input  1  asynchronous, active-low reset.
REQ-006 i_5c, i_10c, i_25c  input  1 each  coin-detected strobes, sampled every cycle.
REQ-007 i_cancel  input  1  refund request.
REQ-008 o_soda  output  1  dispense strobe, one cycle per vend.
REQ-009 o_10c, o_5c  output  1 each  change-coin strobes, at most one coin per cycle.
REQ-010 o_reject  output  1  coin-return strobe for a refused coin.
REQ-011 o_busy  output  1  high while vending or paying out.
REQ-012 o_credit  output  W  current credit in cents.

Function
REQ-013 FSM states SHALL be COLLECT, VEND and CHANGE; credit is a W-bit register.
REQ-014 COLLECT: coin priority SHALL be i_5c > i_10c > i_25c; only the highest-priority asserted coin is considered, and lower-priority simultaneous coins are ignored with no reject.
REQ-015 COLLECT: if credit+coin <= MAX_CREDIT, credit SHALL take credit+coin at the edge; otherwise credit is unchanged and o_reject SHALL be high the following cycle.
REQ-016 COLLECT: if the updated credit >= PRICE, next state SHALL be VEND; otherwise remain in COLLECT.
REQ-017 COLLECT: i_cancel SHALL take priority over coins; any coin in that cycle is rejected (o_reject next cycle); credit > 0 -> CHANGE with credit unchanged; credit == 0 -> no effect.
REQ-018 VEND: lasts exactly one cycle; o_soda = 1; at the exit edge credit SHALL become credit-PRICE; next state CHANGE if the result is > 0, else COLLECT.
REQ-019 CHANGE: each cycle, if credit >= 10 then o_10c = 1 and credit decreases by 10, else o_5c = 1 and credit decreases by 5; the edge that makes credit 0 SHALL return to COLLECT.
REQ-020 o_soda, o_10c and o_5c SHALL be decoded from the registered state and credit only (Moore); they are never high together.
REQ-021 o_busy SHALL be 1 in VEND and CHANGE, and 0 in COLLECT.
REQ-022 Any coin strobe during VEND or CHANGE SHALL be refused: o_reject high next cycle, credit unaffected; i_cancel is ignored in these states.
REQ-023 o_reject SHALL be a registered single-cycle pulse per refusing edge; back-to-back refusals give consecutive high cycles.
REQ-024 Unreachable state encodings SHALL recover to COLLECT with credit 0 on the next edge.
REQ-025 Credit arithmetic SHALL never wrap, which is guaranteed by REQ-003 and REQ-015.

Reset
REQ-026 reset low SHALL immediately force state COLLECT, credit 0, and all outputs 0, independent of clk.
REQ-027 Reset asserted mid-VEND or mid-CHANGE SHALL abandon the payout; no further strobes are issued after release.
REQ-028 After reset deasserts, the first rising edge SHALL be a normal COLLECT cycle.

Verification
REQ-029 Defaults, coins 10,10,10 on successive cycles -> credit 10, 20, 30; one o_soda cycle; one o_5c cycle; credit 0; back to COLLECT.
REQ-030 Defaults, coins 10,10 then 25 -> credit 45, o_soda, then o_10c on two consecutive cycles, o_busy high for 3 cycles.
REQ-031 Defaults, credit 25 already in VEND path: i_5c, i_10c and i_25c asserted together in COLLECT with credit 20 -> only 5c accepted (credit 25 -> VEND), no o_reject.
REQ-032 Defaults, credit 15, then i_cancel together with i_25c -> o_reject one cycle; o_10c then o_5c; credit 0; no o_soda.
REQ-033 PRICE=30, MAX_CREDIT=35, credit 25, insert 25 -> o_reject, credit stays 25; then insert 10 -> credit 35, o_soda, o_5c.
REQ-034 Defaults, reset pulsed low during the first o_10c of a 20-cent payout -> outputs 0 at once, credit 0, no o_10c after release.
